// File: rtl/riscv_gpr_ctrl.sv
// rtl/riscv_gpr_ctrl.sv - GPR write-port controller: init sweep, then round-robin ALU/LSU writeback arbitration
module riscv_gpr_ctrl #(
    parameter logic [31:0] INIT_VALUE = 32'h0000_0000,
    parameter int          NREG       = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_wr_valid,
    input  logic [4:0]  alu_wr_addr,
    input  logic [31:0] alu_wr_data,
    output logic        alu_wr_ready,
    input  logic        lsu_wr_valid,
    input  logic [4:0]  lsu_wr_addr,
    input  logic [31:0] lsu_wr_data,
    output logic        lsu_wr_ready,
    output logic        rf_wr_en,
    output logic [4:0]  rf_wr_addr,
    output logic [31:0] rf_wr_data,
    output logic        init_done
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    localparam logic [5:0] SWEEP_END = 6'(NREG);

    state_t     state;
    state_t     state_next;
    logic [5:0] cnt;
    logic       prio_lsu;   // set when the LSU should win the next tie
    logic       alu_xfer;
    logic       lsu_xfer;

    always_comb begin
        state_next   = state;
        alu_wr_ready = 1'b0;
        lsu_wr_ready = 1'b0;
        unique case (state)
            ST_INIT: begin
                if (cnt == SWEEP_END) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!rst) begin
                    alu_wr_ready = alu_wr_valid && (!lsu_wr_valid || !prio_lsu);
                    lsu_wr_ready = lsu_wr_valid && (!alu_wr_valid || prio_lsu);
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    assign alu_xfer = alu_wr_valid && alu_wr_ready;
    assign lsu_xfer = lsu_wr_valid && lsu_wr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_INIT;
            cnt        <= '0;
            prio_lsu   <= 1'b0;
            rf_wr_en   <= 1'b0;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
            init_done  <= 1'b0;
        end else begin
            state    <= state_next;
            rf_wr_en <= 1'b0;
            unique case (state)
                ST_INIT: begin
                    if (cnt == SWEEP_END) begin
                        init_done <= 1'b1;
                    end else begin
                        rf_wr_en   <= 1'b1;
                        rf_wr_addr <= cnt[4:0];
                        rf_wr_data <= INIT_VALUE;
                        cnt        <= cnt + 6'd1;
                    end
                end
                ST_RUN: begin
                    // x0 writes are accepted but dropped; address/data lines keep their last value
                    if (alu_xfer) begin
                        prio_lsu <= 1'b1;
                        if (alu_wr_addr != 5'd0) begin
                            rf_wr_en   <= 1'b1;
                            rf_wr_addr <= alu_wr_addr;
                            rf_wr_data <= alu_wr_data;
                        end
                    end else if (lsu_xfer) begin
                        prio_lsu <= 1'b0;
                        if (lsu_wr_addr != 5'd0) begin
                            rf_wr_en   <= 1'b1;
                            rf_wr_addr <= lsu_wr_addr;
                            rf_wr_data <= lsu_wr_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
